// File: rtl/bus_slot_scheduler_if.sv
// Bus-slot scheduler signal bundle: CPU/video/Pi-bridge strobes and the Pi valid/done handshake.
// master = scheduler side, slave = address/RAM glue and SPI bridge side.
interface bus_slot_scheduler_if;
  logic bus_rw_ni;
  logic pi_valid_i;
  logic pi_rw_ni;
  logic video_blank_i;
  logic clk_cpu_o;
  logic cpu_enable_o;
  logic cpu_read_o;
  logic cpu_write_o;
  logic io_read_o;
  logic video_select_o;
  logic video_ram_strobe_o;
  logic video_rom_strobe_o;
  logic pi_select_o;
  logic pi_read_o;
  logic pi_write_o;
  logic pi_done_o;

  modport master (
    input  bus_rw_ni, pi_valid_i, pi_rw_ni, video_blank_i,
    output clk_cpu_o, cpu_enable_o, cpu_read_o, cpu_write_o, io_read_o,
           video_select_o, video_ram_strobe_o, video_rom_strobe_o,
           pi_select_o, pi_read_o, pi_write_o, pi_done_o
  );

  modport slave (
    output bus_rw_ni, pi_valid_i, pi_rw_ni, video_blank_i,
    input  clk_cpu_o, cpu_enable_o, cpu_read_o, cpu_write_o, io_read_o,
           video_select_o, video_ram_strobe_o, video_rom_strobe_o,
           pi_select_o, pi_read_o, pi_write_o, pi_done_o
  );
endinterface

// File: rtl/bus_slot_scheduler.sv
// 16-slot time-division scheduler for the shared bus/RAM (video 0-3, Pi 4-7, 6502 8-15).
// Optional macro PI_BLANK_STEAL_EN lets a Pi request take slots 0-3 during video blanking.
module bus_slot_scheduler #(
  parameter bit          VIDEO_EN     = 1'b1,
  parameter int unsigned CPU_RW_START = 9
) (
  input logic                   clk_sys_i,
  input logic                   reset_ni,
  bus_slot_scheduler_if.master  bus
);

  localparam logic [1:0] PI_IDLE    = 2'd0;
  localparam logic [1:0] PI_GRANTED = 2'd1;
  localparam logic [1:0] PI_DONE    = 2'd2;

  localparam logic [3:0] RW_START = 4'(CPU_RW_START);

  typedef struct packed {
    logic clk_cpu;
    logic cpu_enable;
    logic cpu_read;
    logic cpu_write;
    logic io_read;
    logic video_select;
    logic video_ram_strobe;
    logic video_rom_strobe;
    logic pi_select;
    logic pi_read;
    logic pi_write;
    logic pi_done;
  } outs_t;

  logic [3:0] slot_q, slot_d;
  logic [1:0] state_q, state_d;
  logic       steal_q, steal_d;
  logic       pi_rw_q, pi_rw_d;
  outs_t      out_q, out_d;

  logic pi_win, pi_mid, cpu_rw_win, video_win;

  always_comb begin
    slot_d  = slot_q + 4'd1;
    state_d = state_q;
    steal_d = steal_q;
    pi_rw_d = pi_rw_q;

    case (state_q)
      PI_IDLE: begin
        if (slot_q == 4'd3 && bus.pi_valid_i) begin
          state_d = PI_GRANTED;
          steal_d = 1'b0;
          pi_rw_d = bus.pi_rw_ni;
        end
`ifdef PI_BLANK_STEAL_EN
        else if (slot_q == 4'd15 && bus.pi_valid_i && bus.video_blank_i) begin
          state_d = PI_GRANTED;
          steal_d = 1'b1;
          pi_rw_d = bus.pi_rw_ni;
        end
`endif
      end
      PI_GRANTED: begin
        // A stolen grant occupies slots 0-3, a regular one slots 4-7.
        if (slot_q == (steal_q ? 4'd3 : 4'd7))
          state_d = bus.pi_valid_i ? PI_DONE : PI_IDLE;
      end
      PI_DONE: begin
        if (!bus.pi_valid_i)
          state_d = PI_IDLE;
      end
      default: state_d = PI_IDLE;
    endcase

    // Outputs are decoded from the next slot/state so the registered value lines up with slot_q.
    pi_win     = (state_d == PI_GRANTED);
    pi_mid     = (slot_d[1:0] == 2'd1) || (slot_d[1:0] == 2'd2);
    cpu_rw_win = (slot_d >= RW_START) && (slot_d <= 4'd14);
    video_win  = VIDEO_EN && (slot_d[3:2] == 2'b00) && !pi_win;

    out_d                  = '0;
    out_d.clk_cpu          = slot_d[3];
    out_d.cpu_enable       = slot_d[3];
    out_d.cpu_read         = cpu_rw_win && bus.bus_rw_ni;
    out_d.cpu_write        = cpu_rw_win && !bus.bus_rw_ni;
    out_d.io_read          = (slot_d == 4'd14) && bus.bus_rw_ni;
    out_d.video_select     = video_win;
    out_d.video_ram_strobe = video_win && (slot_d[1:0] == 2'd1);
    out_d.video_rom_strobe = video_win && (slot_d[1:0] == 2'd3);
    out_d.pi_select        = pi_win;
    out_d.pi_read          = pi_win && pi_mid && pi_rw_d;
    out_d.pi_write         = pi_win && pi_mid && !pi_rw_d;
    out_d.pi_done          = (state_d == PI_DONE);
  end

  always_ff @(posedge clk_sys_i) begin
    if (!reset_ni) begin
      slot_q  <= '0;
      state_q <= PI_IDLE;
      steal_q <= 1'b0;
      pi_rw_q <= 1'b0;
      out_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      steal_q <= steal_d;
      pi_rw_q <= pi_rw_d;
      out_q   <= out_d;
    end
  end

  assign bus.clk_cpu_o          = out_q.clk_cpu;
  assign bus.cpu_enable_o       = out_q.cpu_enable;
  assign bus.cpu_read_o         = out_q.cpu_read;
  assign bus.cpu_write_o        = out_q.cpu_write;
  assign bus.io_read_o          = out_q.io_read;
  assign bus.video_select_o     = out_q.video_select;
  assign bus.video_ram_strobe_o = out_q.video_ram_strobe;
  assign bus.video_rom_strobe_o = out_q.video_rom_strobe;
  assign bus.pi_select_o        = out_q.pi_select;
  assign bus.pi_read_o          = out_q.pi_read;
  assign bus.pi_write_o         = out_q.pi_write;
  assign bus.pi_done_o          = out_q.pi_done;

endmodule
